muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit that owns the HI/LO pair for the single-cycle MIPS datapath. It replaces the combinational multiply and the ad-hoc hi/lo latches inside the ALU.
- Executes mult, multu, div and divu over multiple cycles using radix-2 shift-add and restoring division.
- Raises a stall to the datapath/PC when an instruction touches HI/LO while an operation is in flight.
- Also serves mthi/mtlo writes and mfhi/mflo reads.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch operation (mult/multu/div/divu decoded)
- op  in  2  00 multu, 01 mult, 10 divu, 11 div; sampled with start
- a  in  WIDTH  rs operand (multiplicand / dividend); sampled with start
- b  in  WIDTH  rt operand (multiplier / divisor); sampled with start
- use_hilo  in  1  current instruction is mult/div/mfhi/mflo/mthi/mtlo
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  WIDTH  data for mthi/mtlo
- stall  out  1  hold PC and suppress regwrite this cycle
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: HI/LO just updated by an operation
- hi  out  WIDTH  HI register (remainder / upper product)
- lo  out  WIDTH  LO register (quotient / lower product)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, hi=0, lo=0, done=0, busy=0, iteration counter=0. Reset mid-operation aborts it, and HI/LO return to 0.
- States:
  - IDLE → RUN on start.
  - RUN → RUN while count<WIDTH-1.
  - RUN → FINISH at count==WIDTH-1.
  - FINISH → IDLE always.
- busy = (state != IDLE), registered.
- stall = use_hilo & busy, combinational. It is never asserted in IDLE, including the start cycle, because the issuing mult/div instruction retires normally.
- start is honoured only in IDLE. It is ignored when busy; this cannot occur while the datapath obeys stall.
- On start:
  - Latch op.
  - Latch magnitudes |a| and |b| for signed ops, raw a and b for unsigned ops.
  - Record the result sign: a[31]^b[31] for the product/quotient, a[31] for the remainder.
- RUN performs exactly one iteration per cycle, WIDTH cycles in total.
  - Multiply: 2*WIDTH accumulator; add multiplicand when the multiplier LSB is 1, then shift right.
  - Divide: shift {rem,quot} left one bit; trial-subtract divisor; keep it if non-negative and set the quotient LSB.
- FINISH:
  - Apply sign correction by two's-complement negation of the product, quotient or remainder as recorded.
  - Write hi/lo at the FINISH→IDLE edge.
  - Register done=1 for the following cycle only.
- Latency: start sampled at edge E0; hi/lo valid and done=1 after edge E0+WIDTH+1 (33 clocks for WIDTH=32).
- Result mapping:
  - mult/multu: hi=upper half, lo=lower half.
  - div/divu: lo=quotient, hi=remainder.
  - Remainder carries the dividend's sign.
- Divide by zero (b==0): full latency still taken; lo=all ones, hi=a as given (unsigned and signed alike).
- Signed overflow: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Moves to HI/LO:
  - mthi/mtlo write at the next edge only in IDLE and only when start=0.
  - Asserted while busy, they are ignored; the datapath is stalled by use_hilo anyway.
  - start has priority over mthi/mtlo in the same cycle.
- Reads: hi/lo outputs are stable throughout RUN/FINISH and hold the previous values until the FINISH edge.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> done exactly 33 clocks after start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- mult a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. div a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064. div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- start at cycle 0, use_hilo=1 from cycle 1 (mflo) -> stall=1 for cycles 1..33 and 0 in the done cycle; start cycle itself stall=0; lo read shows the new quotient.
- mthi wdata=0x12345678 in IDLE -> hi updates next edge; mtlo during busy -> lo unchanged; start+mtlo in the same cycle -> only the operation takes effect.
- reset asserted at cycle 10 of a div -> next cycle busy=0, hi=lo=0, done never pulses; a new start afterwards completes normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit owning the HI/LO pair.
// Radix-2 shift-add multiply and restoring divide, one iteration per clock,
// WIDTH iterations, followed by a sign-correction/commit cycle. Stalls the
// datapath when a HI/LO instruction arrives while an operation is in flight.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_hilo,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    // Two's-complement negation of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] f_neg(input logic signed [WIDTH-1:0] x);
        return -x;
    endfunction

    // Two's-complement negation of the double-width product.
    function automatic logic [2*WIDTH-1:0] f_neg2(input logic signed [2*WIDTH-1:0] x);
        return -x;
    endfunction

    // Magnitude for signed ops; raw value for unsigned ops. The most negative
    // value maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] f_mag(input logic signed [WIDTH-1:0] x,
                                               input logic               is_signed);
        return (is_signed && x[WIDTH-1]) ? f_neg(x) : x;
    endfunction

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_busy;
    logic                 r_done;
    logic [CW-1:0]        r_count;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    // Operation context captured at start; datapath only, no reset needed.
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_div0;
    logic [WIDTH-1:0]     r_opb;
    logic [2*WIDTH-1:0]   r_acc;

    logic                 w_load;
    logic                 w_iter;
    logic                 w_commit;
    logic                 w_move_ok;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_sh;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_hi_res;
    logic [WIDTH-1:0]     w_lo_res;

    // State register; busy is registered alongside so it mirrors state != IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
        end
    end

    // Next-state logic: IDLE -> RUN on start, WIDTH RUN cycles, one FINISH.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_RUN;
            S_RUN:    if (r_count == LAST) w_state_next = S_FINISH;
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        w_load    = 1'b0;
        w_iter    = 1'b0;
        w_commit  = 1'b0;
        w_move_ok = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load    = start;
                w_move_ok = ~start;
            end
            S_RUN:    w_iter   = 1'b1;
            S_FINISH: w_commit = 1'b1;
            default: ;
        endcase
    end

    // Iteration counter, cleared on launch and advanced once per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= '0;
        end else if (w_iter) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Operand magnitudes and one shift-add / restoring-divide step.
    always_comb begin
        w_mag_a    = f_mag(a, op[0]);
        w_mag_b    = f_mag(b, op[0]);

        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
        w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                              : {1'b0, r_acc[2*WIDTH-1:1]};

        // Shifted partial remainder needs one extra bit before the trial subtract.
        w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_diff = w_div_sh - {1'b0, r_opb};
        w_div_ge   = (w_div_sh >= {1'b0, r_opb});
        w_div_next = w_div_ge ? {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                              : {w_div_sh[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b0};
    end

    // Accumulator: loaded at launch, stepped in RUN. For multiply the upper
    // half accumulates and the multiplier shifts out of the lower half; for
    // divide the upper half is the remainder and the lower half the quotient.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_is_div <= op[1];
            r_neg_q  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r  <= op[0] & a[WIDTH-1];
            r_div0   <= (b == '0);
            r_opb    <= op[1] ? w_mag_b : w_mag_a;
            r_acc    <= op[1] ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
        end else if (w_iter) begin
            r_acc    <= r_is_div ? w_div_next : w_mul_next;
        end
    end

    // Sign correction and result mapping applied in FINISH. Divide by zero
    // forces an all-ones quotient; the remainder already equals the dividend
    // because every trial subtract of zero succeeds.
    always_comb begin
        w_prod   = r_neg_q ? f_neg2(r_acc) : r_acc;
        w_quot   = r_div0 ? {WIDTH{1'b1}}
                          : (r_neg_q ? f_neg(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0]);
        w_rem    = r_neg_r ? f_neg(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
        w_hi_res = r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
        w_lo_res = r_is_div ? w_quot : w_prod[WIDTH-1:0];
    end

    // HI/LO commit at the FINISH edge, moves only in IDLE without start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_hi <= w_hi_res;
                r_lo <= w_lo_res;
            end else if (w_move_ok) begin
                if (mthi) r_hi <= wdata;
                if (mtlo) r_lo <= wdata;
            end
        end
    end

    assign stall = use_hilo & r_busy;
    assign busy  = r_busy;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed test-plan vectors plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         use_hilo;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;
    bit mt_during_run = 1'b0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .use_hilo(use_hilo), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference model: MIPS semantics via 64-bit integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin p = {32'd0, x} * {32'd0, y}; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = 64'(sx * sy); eh = p[63:32]; el = p[31:0]; end
            2'b10: begin
                if (y == 0) begin el = 32'hFFFF_FFFF; eh = x; end
                else begin el = x / y; eh = x % y; end
            end
            default: begin
                if (y == 0) begin el = 32'hFFFF_FFFF; eh = x; end
                else begin q = sx / sy; r = sx % sy; el = q[31:0]; eh = r[31:0]; end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Launch one op (from an IDLE cycle, #1 after an edge) and run to done.
    // lat: edges after the start edge until done; bcnt: cycles with busy=1;
    // held: hi/lo never changed before done; early: done seen just after start.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt, output bit held, output bit early);
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        start = 1'b1; op = o; a = x; b = y;
        mthi = mt_during_run; mtlo = mt_during_run; wdata = $urandom;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        lat = 0; bcnt = 0; held = 1'b1; early = done;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            wdata = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        mthi = 1'b0; mtlo = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        use_hilo = 1'b1; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
        use_hilo = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  dop [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11};
        logic [31:0] da  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
        logic [31:0] db  [5] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] dh  [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0064, 32'h0};
        logic [31:0] dl  [5] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        int lat, bcnt; bit held, early;
        for (int i = 0; i < 5; i++) begin
            do_op(dop[i], da[i], db[i], lat, bcnt, held, early);
            checks++; if (lat !== 33) begin errors++; $display("FAIL dir%0d_latency: got %0d want 33", i, lat); end
            checks++; if (bcnt !== 33) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d want 33", i, bcnt); end
            checks++; if (hi !== dh[i]) begin errors++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, dh[i]); end
            checks++; if (lo !== dl[i]) begin errors++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, dl[i]); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_at_done: got %0b want 0", i, busy); end
            checks++; if (early !== 1'b0) begin errors++; $display("FAIL dir%0d_early_done: got %0b want 0", i, early); end
        end
    endtask

    task automatic test_stall();
        int nstall;
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7; use_hilo = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_start_cycle: got %0b want 0", stall); end
        @(posedge clk); #1;
        start = 1'b0;
        nstall = 0;
        for (int c = 1; c <= 33; c++) begin
            if (stall === 1'b1) nstall++;
            @(posedge clk); #1;
        end
        checks++; if (nstall !== 33) begin errors++; $display("FAIL stall_cycles: got %0d want 33", nstall); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %0b want 1", done); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_done_cycle: got %0b want 0", stall); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL stall_lo: got %h want %h", lo, 32'd14); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL stall_hi: got %h want %h", hi, 32'd2); end
        use_hilo = 1'b0;
    endtask

    task automatic test_moves();
        logic [31:0] l0, eh, el;
        int lat, bcnt; bit held, early;
        l0 = lo;
        mthi = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1; mthi = 1'b0;
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_idle: got %h want 12345678", hi); end
        checks++; if (lo !== l0) begin errors++; $display("FAIL mthi_lo_kept: got %h want %h", lo, l0); end
        mtlo = 1'b1; wdata = 32'hCAFE_0001;
        @(posedge clk); #1; mtlo = 1'b0;
        checks++; if (lo !== 32'hCAFE_0001) begin errors++; $display("FAIL mtlo_idle: got %h want cafe0001", lo); end
        // mthi/mtlo asserted in the start cycle and throughout the run.
        mt_during_run = 1'b1;
        do_op(2'b10, 32'd1000, 32'd7, lat, bcnt, held, early);
        mt_during_run = 1'b0;
        model(2'b10, 32'd1000, 32'd7, eh, el);
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL mt_busy_held: got %0b want 1", held); end
        checks++; if (lo !== el) begin errors++; $display("FAIL mt_busy_lo: got %h want %h", lo, el); end
        checks++; if (hi !== eh) begin errors++; $display("FAIL mt_busy_hi: got %h want %h", hi, eh); end
    endtask

    task automatic test_reset_midop();
        bit seen;
        int lat, bcnt; bit held, early;
        logic [31:0] eh, el;
        start = 1'b1; op = 2'b11; a = 32'hFFFF_FFF9; b = 32'd2;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %0b want 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h want 0", lo); end
        seen = 1'b0;
        repeat (40) begin
            if (done !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_done_pulse: got %0b want 0", seen); end
        do_op(2'b01, 32'd123456, 32'hFFFF_FF00, lat, bcnt, held, early);
        model(2'b01, 32'd123456, 32'hFFFF_FF00, eh, el);
        checks++; if (lat !== 33) begin errors++; $display("FAIL rst_after_latency: got %0d want 33", lat); end
        checks++; if ({hi, lo} !== {eh, el}) begin errors++; $display("FAIL rst_after_result: got %h_%h want %h_%h", hi, lo, eh, el); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt; bit held, early;
        logic [31:0] eh, el;
        for (int i = 0; i < 3; i++) begin
            do_op(2'(i), 32'hDEAD_BEEF - 32'(i), 32'h0000_1235 + 32'(i), lat, bcnt, held, early);
            model(2'(i), 32'hDEAD_BEEF - 32'(i), 32'h0000_1235 + 32'(i), eh, el);
            checks++; if (early !== 1'b0) begin errors++; $display("FAIL b2b%0d_done_width: got %0b want 0", i, early); end
            checks++; if ({hi, lo} !== {eh, el}) begin errors++; $display("FAIL b2b%0d_result: got %h_%h want %h_%h", i, hi, lo, eh, el); end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_single: got %0b want 0", done); end
    endtask

    task automatic test_random();
        int lat, bcnt; bit held, early;
        logic [1:0]  o;
        logic [31:0] x, y, eh, el;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick();
            y = pick();
            model(o, x, y, eh, el);
            do_op(o, x, y, lat, bcnt, held, early);
            checks++; if (lat !== 33) begin errors++; $display("FAIL rnd%0d_latency: got %0d want 33", i, lat); end
            checks++; if (held !== 1'b1) begin errors++; $display("FAIL rnd%0d_hilo_held: got %0b want 1", i, held); end
            checks++; if (hi !== eh) begin errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h want %h", i, o, x, y, hi, eh); end
            checks++; if (lo !== el) begin errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h want %h", i, o, x, y, lo, el); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_moves();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
